// File: rtl/mem_io_ctrl.sv
// CPU-side memory/IO controller: SRAM accesses with configurable wait states,
// plus a switch/hex register at IO_BASE. Define MEM_IO_LED_EN to add an LED register at IO_BASE-1.
module mem_io_ctrl #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                WAIT_STATES = 2,
  parameter int                N_HEX       = 4,
  parameter logic [ADDR_W-1:0] IO_BASE     = '1
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Req,
  input  logic                Wr,
  input  logic [ADDR_W-1:0]   Addr,
  input  logic [DATA_W-1:0]   Wdata,
  output logic [DATA_W-1:0]   Rdata,
  output logic                Ready,
  input  logic [DATA_W-1:0]   Switches,
  output logic [ADDR_W-1:0]   Sram_addr,
  output logic [DATA_W-1:0]   Sram_wdata,
  input  logic [DATA_W-1:0]   Sram_rdata,
  output logic                Sram_oe,
  output logic                Sram_we,
  output logic [4*N_HEX-1:0]  Hex_out,
  output logic [DATA_W-1:0]   Led_out
);

  localparam logic [ADDR_W-1:0] LED_ADDR = IO_BASE - ADDR_W'(1);
  localparam logic [3:0]        WS       = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IO     = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                wr_r;
  logic [3:0]          cnt_r;
  logic [DATA_W-1:0]   rdata_r;
  logic [4*N_HEX-1:0]  hex_r;
  logic                io_hit_s;
  logic                accept_s;
  logic                last_access_s;

  // Decode which incoming addresses take the register path instead of SRAM.
  always_comb begin
    io_hit_s = (Addr == IO_BASE);
`ifdef MEM_IO_LED_EN
    if (Addr == LED_ADDR) begin
      io_hit_s = 1'b1;
    end else begin
      io_hit_s = (Addr == IO_BASE);
    end
`endif
  end

  assign accept_s      = (state_r == IDLE) && Req;
  assign last_access_s = (state_r == ACCESS) && (cnt_r == 4'd0);

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; requests outside IDLE are simply not looked at.
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (Req) begin
          next_state_s = io_hit_s ? IO : ACCESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      IO:     next_state_s = DONE;
      ACCESS: begin
        if (cnt_r == 4'd0) begin
          next_state_s = DONE;
        end else begin
          next_state_s = ACCESS;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Strobes and completion decoded straight from the state register so reset drops them at once.
  always_comb begin
    Sram_oe = 1'b0;
    Sram_we = 1'b0;
    Ready   = 1'b0;
    case (state_r)
      ACCESS: begin
        Sram_oe = ~wr_r;
        Sram_we = wr_r;
      end
      DONE:    Ready = 1'b1;
      default: Ready = 1'b0;
    endcase
  end

  // Request latch and wait-state down-counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_r  <= '0;
      wdata_r <= '0;
      wr_r    <= 1'b0;
      cnt_r   <= 4'd0;
    end else if (accept_s) begin
      addr_r  <= Addr;
      wdata_r <= Wdata;
      wr_r    <= Wr;
      cnt_r   <= WS;
    end else if ((state_r == ACCESS) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Read data register: only completed reads update it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rdata_r <= '0;
    end else if ((state_r == IO) && !wr_r && (addr_r == IO_BASE)) begin
      rdata_r <= Switches;
`ifdef MEM_IO_LED_EN
    end else if ((state_r == IO) && !wr_r && (addr_r == LED_ADDR)) begin
      rdata_r <= Led_out;
`endif
    end else if (last_access_s && !wr_r) begin
      rdata_r <= Sram_rdata;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // Hex display register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hex_r <= '0;
    end else if ((state_r == IO) && wr_r && (addr_r == IO_BASE)) begin
      hex_r <= wdata_r[4*N_HEX-1:0];
    end else begin
      hex_r <= hex_r;
    end
  end

`ifdef MEM_IO_LED_EN
  logic [DATA_W-1:0] led_r;

  // LED register one below the hex/switch address.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      led_r <= '0;
    end else if ((state_r == IO) && wr_r && (addr_r == LED_ADDR)) begin
      led_r <= wdata_r;
    end else begin
      led_r <= led_r;
    end
  end

  assign Led_out = led_r;
`else
  assign Led_out = '0;
`endif

  assign Rdata      = rdata_r;
  assign Hex_out    = hex_r;
  assign Sram_addr  = addr_r;
  assign Sram_wdata = wdata_r;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Self-checking bench for mem_io_ctrl: directed cases then random transactions
// against a transaction-level model (register values, SRAM contents, latencies).
module tb_mem_io_ctrl;

  localparam int WS = 2;
`ifdef MEM_IO_LED_EN
  localparam bit LED_EN = 1'b1;
`else
  localparam bit LED_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Req = 1'b0;
  logic        Wr = 1'b0;
  logic [15:0] Addr = 16'h0000;
  logic [15:0] Wdata = 16'h0000;
  logic [15:0] Rdata;
  logic        Ready;
  logic [15:0] Switches = 16'h0000;
  logic [15:0] Sram_addr;
  logic [15:0] Sram_wdata;
  logic [15:0] Sram_rdata = 16'h0000;
  logic        Sram_oe;
  logic        Sram_we;
  logic [15:0] Hex_out;
  logic [15:0] Led_out;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_rdata = 16'h0000;
  logic [15:0] m_hex   = 16'h0000;
  logic [15:0] m_led   = 16'h0000;
  logic [15:0] mem [logic [15:0]];

  mem_io_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Wr(Wr), .Addr(Addr), .Wdata(Wdata),
    .Rdata(Rdata), .Ready(Ready), .Switches(Switches), .Sram_addr(Sram_addr),
    .Sram_wdata(Sram_wdata), .Sram_rdata(Sram_rdata), .Sram_oe(Sram_oe),
    .Sram_we(Sram_we), .Hex_out(Hex_out), .Led_out(Led_out)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access: issue at negedge, accepted at the next posedge; count negedges to Ready.
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input int exp_lat, input int exp_oe, input int exp_we, input string tag);
    int lat, n_oe, n_we;
    lat = 0; n_oe = 0; n_we = 0;
    @(negedge Clk);
    Req = 1'b1; Wr = w; Addr = a; Wdata = d;
    @(posedge Clk);
    #1;
    Req = 1'b0; Wr = 1'b0; Addr = 16'($urandom); Wdata = 16'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      chk({tag, "_excl"}, {31'd0, Sram_oe & Sram_we}, 32'd0);
      if (Sram_oe) n_oe++;
      if (Sram_we) begin
        n_we++;
        chk({tag, "_swdata"}, {16'd0, Sram_wdata}, {16'd0, d});
      end
      if (Sram_oe || Sram_we) chk({tag, "_saddr"}, {16'd0, Sram_addr}, {16'd0, a});
      if (Ready) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_oe_cycles"}, n_oe, exp_oe);
    chk({tag, "_we_cycles"}, n_we, exp_we);
    @(negedge Clk);
    chk({tag, "_ready_pulse"}, {31'd0, Ready}, 32'd0);
  endtask

  // Model one transaction, run it, and compare the visible registers.
  task automatic txn(input logic w, input logic [15:0] a, input logic [15:0] d, input string tag);
    bit is_io;
    is_io = (a == 16'hFFFF) || (LED_EN && (a == 16'hFFFE));
    if (!w && !is_io) begin
      if (!mem.exists(a)) mem[a] = 16'($urandom);
      Sram_rdata = mem[a];
    end
    if (is_io) begin
      if (w && a == 16'hFFFF) m_hex = d;
      else if (w) m_led = d;
      else if (a == 16'hFFFF) m_rdata = Switches;
      else m_rdata = m_led;
      access(w, a, d, 2, 0, 0, tag);
    end else if (w) begin
      mem[a] = d;
      access(w, a, d, WS + 2, 0, WS + 1, tag);
    end else begin
      m_rdata = mem[a];
      access(w, a, d, WS + 2, WS + 1, 0, tag);
    end
    chk({tag, "_rdata"}, {16'd0, Rdata}, {16'd0, m_rdata});
    chk({tag, "_hex"}, {16'd0, Hex_out}, {16'd0, m_hex});
    chk({tag, "_led"}, {16'd0, Led_out}, {16'd0, m_led});
  endtask

  initial begin
    int n_rdy, n_we, cls;
    logic [15:0] a;
    #12;
    chk("rst_rdata", {16'd0, Rdata}, 32'd0);
    chk("rst_ready", {31'd0, Ready}, 32'd0);
    chk("rst_strobes", {30'd0, Sram_oe, Sram_we}, 32'd0);
    chk("rst_hex_led", {Hex_out, Led_out}, 32'd0);
    chk("rst_sram_bus", {Sram_addr, Sram_wdata}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    mem[16'h0010] = 16'hBEEF;
    txn(1'b0, 16'h0010, 16'h0000, "sram_rd_beef");
    txn(1'b1, 16'hFFFF, 16'h1234, "hex_wr");
    Switches = 16'h00A5;
    txn(1'b0, 16'hFFFF, 16'h0000, "sw_rd");
    txn(1'b1, 16'hFFFE, 16'h0F0F, "led_addr_wr");
    txn(1'b0, 16'hFFFE, 16'h0000, "led_addr_rd");

    // Req held high through an SRAM write: one access, one Ready, re-accept after DONE.
    n_rdy = 0; n_we = 0;
    @(negedge Clk);
    Req = 1'b1; Wr = 1'b1; Addr = 16'h0040; Wdata = 16'hC0DE;
    mem[16'h0040] = 16'hC0DE;
    for (int k = 1; k <= WS + 3; k++) begin
      @(negedge Clk);
      if (Ready) n_rdy++;
      if (Sram_we) n_we++;
    end
    chk("held_ready_count", n_rdy, 1);
    chk("held_we_count", n_we, WS + 1);
    @(negedge Clk);
    chk("held_reaccept", {31'd0, Sram_we}, 32'd1);
    Req = 1'b0;
    n_rdy = 0;
    for (int k = 0; k < 20 && n_rdy == 0; k++) begin
      @(negedge Clk);
      if (Ready) n_rdy++;
    end
    chk("held_second_done", n_rdy, 1);
    txn(1'b0, 16'h0040, 16'h0000, "held_readback");

    // Reset asserted in the second ACCESS cycle of a read.
    @(negedge Clk);
    Req = 1'b1; Wr = 1'b0; Addr = 16'h0020; Sram_rdata = 16'h5555;
    @(posedge Clk);
    #1;
    Req = 1'b0;
    @(negedge Clk);
    chk("mid_oe_before_rst", {31'd0, Sram_oe}, 32'd1);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {30'd0, Sram_oe, Sram_we}, 32'd0);
    chk("mid_rst_ready", {31'd0, Ready}, 32'd0);
    chk("mid_rst_rdata", {16'd0, Rdata}, 32'd0);
    chk("mid_rst_hex_led", {Hex_out, Led_out}, 32'd0);
    chk("mid_rst_sram_bus", {Sram_addr, Sram_wdata}, 32'd0);
    m_rdata = 16'h0000; m_hex = 16'h0000; m_led = 16'h0000;
    @(negedge Clk);
    Reset_n = 1'b1;
    n_rdy = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      if (Ready) n_rdy++;
    end
    chk("mid_rst_no_ready", n_rdy, 0);
    txn(1'b0, 16'h0010, 16'h0000, "post_rst_rd");

    // Random traffic over IO, LED-slot and low SRAM addresses.
    for (int i = 0; i < 30; i++) begin
      cls = $urandom_range(0, 3);
      if (cls == 0) a = 16'hFFFF;
      else if (cls == 1) a = 16'hFFFE;
      else a = 16'($urandom_range(0, 31));
      Switches = 16'($urandom);
      txn(1'($urandom_range(0, 1)), a, 16'($urandom), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
